// File: rtl/axil_mst_arbiter.sv
// Two-master, one-slave AXI-Lite arbiter: one transaction end to end at a time,
// round-robin between masters, writes ahead of reads within the winning master.
module axil_mst_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset,
  // master 0
  input  logic                    m0_awvalid,
  output logic                    m0_awready,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic                    m0_wvalid,
  output logic                    m0_wready,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic                    m0_bvalid,
  input  logic                    m0_bready,
  output logic [1:0]              m0_bresp,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  input  logic [ADDR_WIDTH-1:0]   m0_araddr,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  // master 1
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  output logic [1:0]              m1_bresp,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  input  logic [ADDR_WIDTH-1:0]   m1_araddr,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  // slave
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  input  logic [1:0]              s_bresp,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp
);
  localparam int NUM_MST = 2;
  localparam int STRB_W  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_gnt_q, last_gnt_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   win, aw_hs, w_hs;

  // masters gathered into packed arrays so the granted one is a simple index
  logic [NUM_MST-1:0]                 awvalid_m, wvalid_m, bready_m, arvalid_m, rready_m, req;
  logic [NUM_MST-1:0][ADDR_WIDTH-1:0] awaddr_m, araddr_m;
  logic [NUM_MST-1:0][DATA_WIDTH-1:0] wdata_m;
  logic [NUM_MST-1:0][STRB_W-1:0]     wstrb_m;

  logic [NUM_MST-1:0]                 awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [NUM_MST-1:0][1:0]            bresp_m, rresp_m;
  logic [NUM_MST-1:0][DATA_WIDTH-1:0] rdata_m;

  assign awvalid_m = {m1_awvalid, m0_awvalid};
  assign wvalid_m  = {m1_wvalid,  m0_wvalid};
  assign bready_m  = {m1_bready,  m0_bready};
  assign arvalid_m = {m1_arvalid, m0_arvalid};
  assign rready_m  = {m1_rready,  m0_rready};
  assign awaddr_m  = {m1_awaddr,  m0_awaddr};
  assign araddr_m  = {m1_araddr,  m0_araddr};
  assign wdata_m   = {m1_wdata,   m0_wdata};
  assign wstrb_m   = {m1_wstrb,   m0_wstrb};
  // a lone wvalid does not count as a request
  assign req       = awvalid_m | arvalid_m;

  assign m0_awready = awready_m[0];
  assign m0_wready  = wready_m[0];
  assign m0_bvalid  = bvalid_m[0];
  assign m0_bresp   = bresp_m[0];
  assign m0_arready = arready_m[0];
  assign m0_rvalid  = rvalid_m[0];
  assign m0_rdata   = rdata_m[0];
  assign m0_rresp   = rresp_m[0];
  assign m1_awready = awready_m[1];
  assign m1_wready  = wready_m[1];
  assign m1_bvalid  = bvalid_m[1];
  assign m1_bresp   = bresp_m[1];
  assign m1_arready = arready_m[1];
  assign m1_rvalid  = rvalid_m[1];
  assign m1_rdata   = rdata_m[1];
  assign m1_rresp   = rresp_m[1];

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    win        = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    awready_m  = '0;
    wready_m   = '0;
    bvalid_m   = '0;
    bresp_m    = '0;
    arready_m  = '0;
    rvalid_m   = '0;
    rresp_m    = '0;
    rdata_m    = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win     = (&req) ? ~last_gnt_q : req[1];
          gnt_d   = win;
          state_d = awvalid_m[win] ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // done flags stop re-presenting a channel that already handshook
        s_awvalid           = awvalid_m[gnt_q] & ~aw_done_q;
        s_awaddr            = awaddr_m[gnt_q];
        s_wvalid            = wvalid_m[gnt_q] & ~w_done_q;
        s_wdata             = wdata_m[gnt_q];
        s_wstrb             = wstrb_m[gnt_q];
        awready_m[gnt_q]    = s_awready & ~aw_done_q;
        wready_m[gnt_q]     = s_wready & ~w_done_q;
        aw_hs               = awvalid_m[gnt_q] & ~aw_done_q & s_awready;
        w_hs                = wvalid_m[gnt_q] & ~w_done_q & s_wready;
        aw_done_d           = aw_done_q | aw_hs;
        w_done_d            = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        s_bready        = bready_m[gnt_q];
        bvalid_m[gnt_q] = s_bvalid;
        bresp_m[gnt_q]  = s_bresp;
        if (s_bvalid && bready_m[gnt_q]) begin
          last_gnt_d = gnt_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      RD_REQ: begin
        s_arvalid        = arvalid_m[gnt_q];
        s_araddr         = araddr_m[gnt_q];
        arready_m[gnt_q] = s_arready;
        if (arvalid_m[gnt_q] && s_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        s_rready        = rready_m[gnt_q];
        rvalid_m[gnt_q] = s_rvalid;
        rdata_m[gnt_q]  = s_rdata;
        rresp_m[gnt_q]  = s_rresp;
        if (s_rvalid && rready_m[gnt_q]) begin
          last_gnt_d = gnt_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_mst_arbiter.sv
// Scoreboard bench for axil_mst_arbiter: directed master transactions push expected
// slave-side and master-side beats; a negedge monitor pops and compares on handshakes.
module tb_axil_mst_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic axi_clk = 1'b0;
  logic axi_reset = 1'b1;
  always #5 axi_clk = ~axi_clk;

  logic          m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
  logic [AW-1:0] m_awaddr[2], m_araddr[2];
  logic [DW-1:0] m_wdata[2];
  logic [SW-1:0] m_wstrb[2];
  logic          m_awready_o[2], m_wready_o[2], m_bvalid_o[2], m_arready_o[2], m_rvalid_o[2];
  logic [1:0]    m_bresp_o[2], m_rresp_o[2];
  logic [DW-1:0] m_rdata_o[2];

  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    s_bresp, s_rresp;

  axil_mst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready_o[0]), .m0_awaddr(m_awaddr[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready_o[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_bvalid(m_bvalid_o[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp_o[0]),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready_o[0]), .m0_araddr(m_araddr[0]),
    .m0_rvalid(m_rvalid_o[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata_o[0]), .m0_rresp(m_rresp_o[0]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready_o[1]), .m1_awaddr(m_awaddr[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready_o[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_bvalid(m_bvalid_o[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp_o[1]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready_o[1]), .m1_araddr(m_araddr[1]),
    .m1_rvalid(m_rvalid_o[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata_o[1]), .m1_rresp(m_rresp_o[1]),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  int checks = 0;
  int failures = 0;

  logic [AW-1:0]    exp_aw[$];
  logic [AW-1:0]    exp_ar[$];
  logic [SW+DW-1:0] exp_w[$];
  logic [2:0]       exp_b[$];
  logic [DW+2:0]    exp_r[$];

  int         aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0] sl_bresp = 2'b00;
  logic [DW-1:0] rd_data = 32'h1234_5678;
  bit         chk_m1_quiet = 1'b0;

  logic m0_busy, m1_busy, all_out;
  assign m0_busy = |{m_awready_o[0], m_wready_o[0], m_bvalid_o[0], m_arready_o[0], m_rvalid_o[0],
                     m_bresp_o[0], m_rresp_o[0], m_rdata_o[0]};
  assign m1_busy = |{m_awready_o[1], m_wready_o[1], m_bvalid_o[1], m_arready_o[1], m_rvalid_o[1],
                     m_bresp_o[1], m_rresp_o[1], m_rdata_o[1]};
  assign all_out = m0_busy | m1_busy |
                   (|{s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid, s_araddr, s_rready});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [1:0] resp);
    exp_aw.push_back(a);
    exp_w.push_back({s, d});
    exp_b.push_back({id[0], resp});
  endtask

  task automatic exp_read(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_ar.push_back(a);
    exp_r.push_back({id[0], 2'b00, d});
  endtask

  // master write: AW/W (W optionally leading by wlead cycles), then B; aborts on reset
  task automatic do_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int wlead);
    bit ah, wh, bh, b_ok;
    int n;
    b_ok = 1'b0;
    n = 0;
    m_awaddr[id] = a;
    m_wdata[id]  = d;
    m_wstrb[id]  = s;
    m_bready[id] = 1'b1;
    if (wlead > 0) begin
      m_wvalid[id] = 1'b1;
      repeat (wlead) @(posedge axi_clk);
      #1;
    end
    m_awvalid[id] = 1'b1;
    m_wvalid[id]  = 1'b1;
    while (!b_ok && !axi_reset && n < 200) begin
      @(negedge axi_clk);
      ah = m_awvalid[id] & m_awready_o[id];
      wh = m_wvalid[id] & m_wready_o[id];
      bh = m_bvalid_o[id] & m_bready[id];
      @(posedge axi_clk);
      #1;
      n++;
      if (ah) m_awvalid[id] = 1'b0;
      if (wh) m_wvalid[id] = 1'b0;
      if (bh) b_ok = 1'b1;
    end
    if (!axi_reset) chk("wr_complete", b_ok, 1);
    m_awvalid[id] = 1'b0;
    m_wvalid[id]  = 1'b0;
    m_bready[id]  = 1'b0;
    m_awaddr[id]  = '0;
    m_wdata[id]   = '0;
    m_wstrb[id]   = '0;
  endtask

  task automatic do_read(input int id, input logic [AW-1:0] a);
    bit ah, rh, r_ok;
    int n;
    r_ok = 1'b0;
    n = 0;
    m_araddr[id]  = a;
    m_arvalid[id] = 1'b1;
    m_rready[id]  = 1'b1;
    while (!r_ok && !axi_reset && n < 200) begin
      @(negedge axi_clk);
      ah = m_arvalid[id] & m_arready_o[id];
      rh = m_rvalid_o[id] & m_rready[id];
      @(posedge axi_clk);
      #1;
      n++;
      if (ah) m_arvalid[id] = 1'b0;
      if (rh) r_ok = 1'b1;
    end
    if (!axi_reset) chk("rd_complete", r_ok, 1);
    m_arvalid[id] = 1'b0;
    m_rready[id]  = 1'b0;
    m_araddr[id]  = '0;
  endtask

  // slave model: readies after configurable valid-cycle delays, B after b_dly cycles, R next cycle
  initial begin
    bit aw_got, w_got, ar_got, awh, wh, bh, arh, rh;
    int aw_cnt, w_cnt, b_cnt;
    aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    forever begin
      @(negedge axi_clk);
      awh = s_awvalid & s_awready;
      wh  = s_wvalid & s_wready;
      bh  = s_bvalid & s_bready;
      arh = s_arvalid & s_arready;
      rh  = s_rvalid & s_rready;
      if (s_awvalid && !awh) aw_cnt++;
      if (s_wvalid && !wh) w_cnt++;
      @(posedge axi_clk);
      #1;
      if (axi_reset) begin
        aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
      end else begin
        if (awh) aw_got = 1;
        if (wh) w_got = 1;
        if (bh) begin
          aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
          s_bvalid = 0; s_bresp = 0;
        end else if (aw_got && w_got && !s_bvalid) begin
          if (b_cnt >= b_dly) begin
            s_bvalid = 1;
            s_bresp  = sl_bresp;
          end else b_cnt++;
        end
        s_awready = !aw_got && (aw_cnt >= aw_dly);
        s_wready  = !w_got && (w_cnt >= w_dly);
        if (arh) begin
          ar_got = 1; s_rvalid = 1; s_rdata = rd_data; s_rresp = 0;
        end
        if (rh) begin
          ar_got = 0; s_rvalid = 0; s_rdata = 0;
        end
        s_arready = !ar_got;
      end
    end
  end

  // monitor: pops the scoreboard on every observed handshake
  initial begin
    forever begin
      @(negedge axi_clk);
      if (!axi_reset) begin
        chk("mst_exclusive", m0_busy & m1_busy, 0);
        if (chk_m1_quiet) chk("m1_quiet", m1_busy, 0);
        if (s_awvalid && s_awready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", s_awaddr, 'hx);
          else chk("s_awaddr", s_awaddr, exp_aw.pop_front());
        end
        if (s_wvalid && s_wready) begin
          if (exp_w.size() == 0) chk("w_unexpected", s_wdata, 'hx);
          else chk("s_wstrb_wdata", {s_wstrb, s_wdata}, exp_w.pop_front());
        end
        if (s_arvalid && s_arready) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", s_araddr, 'hx);
          else chk("s_araddr", s_araddr, exp_ar.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
          if (m_bvalid_o[i] && m_bready[i]) begin
            if (exp_b.size() == 0) chk("b_unexpected", i, 'hx);
            else chk("b_id_resp", {i[0], m_bresp_o[i]}, exp_b.pop_front());
          end
          if (m_rvalid_o[i] && m_rready[i]) begin
            if (exp_r.size() == 0) chk("r_unexpected", i, 'hx);
            else chk("r_id_resp_data", {i[0], m_rresp_o[i], m_rdata_o[i]}, exp_r.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_awvalid[i] = 0; m_wvalid[i] = 0; m_bready[i] = 0; m_arvalid[i] = 0; m_rready[i] = 0;
      m_awaddr[i] = 0; m_araddr[i] = 0; m_wdata[i] = 0; m_wstrb[i] = 0;
    end
    repeat (3) @(posedge axi_clk);
    #1;
    chk("reset_outputs", all_out, 0);
    @(negedge axi_clk);
    axi_reset = 1'b0;
    @(posedge axi_clk);
    #1;

    // tie after reset: m0 first, then m1; second tie alternates the same way
    exp_write(0, 15'h0100, 32'hA0A0_0001, 4'hF, 2'b00);
    exp_write(1, 15'h0200, 32'hB0B0_0002, 4'h3, 2'b00);
    fork
      do_write(0, 15'h0100, 32'hA0A0_0001, 4'hF, 0);
      do_write(1, 15'h0200, 32'hB0B0_0002, 4'h3, 0);
    join
    exp_write(0, 15'h0104, 32'hA0A0_0003, 4'h1, 2'b00);
    exp_write(1, 15'h0204, 32'hB0B0_0004, 4'h8, 2'b00);
    fork
      do_write(0, 15'h0104, 32'hA0A0_0003, 4'h1, 0);
      do_write(1, 15'h0204, 32'hB0B0_0004, 4'h8, 0);
    join

    // single m0 write: one-cycle arbitration latency, m1 stays quiet
    exp_write(0, 15'h0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
    chk_m1_quiet = 1'b1;
    fork
      do_write(0, 15'h0010, 32'hDEAD_BEEF, 4'hF, 0);
      begin
        @(negedge axi_clk);
        chk("arb_cycle_idle", all_out, 0);
        @(negedge axi_clk);
        chk("fwd_aw_w_valid", {s_awvalid, s_wvalid}, 2'b11);
      end
    join
    chk_m1_quiet = 1'b0;

    // m1 write and read together: write first
    exp_write(1, 15'h0020, 32'h0BAD_F00D, 4'h3, 2'b00);
    exp_read(1, 15'h0024, 32'h1234_5678);
    fork
      do_write(1, 15'h0020, 32'h0BAD_F00D, 4'h3, 0);
      do_read(1, 15'h0024);
    join

    // slow slave with error response
    aw_dly = 3; w_dly = 1; b_dly = 5; sl_bresp = 2'b10;
    exp_write(0, 15'h0030, 32'hCAFE_0030, 4'hC, 2'b10);
    do_write(0, 15'h0030, 32'hCAFE_0030, 4'hC, 0);
    aw_dly = 0; w_dly = 0; b_dly = 0; sl_bresp = 2'b00;

    // W leads AW by two cycles: no grant until awvalid
    exp_write(0, 15'h0040, 32'h5555_AAAA, 4'hF, 2'b00);
    fork
      do_write(0, 15'h0040, 32'h5555_AAAA, 4'hF, 2);
      repeat (2) begin
        @(negedge axi_clk);
        chk("wlead_no_grant", {s_wvalid, m_wready_o[0]}, 2'b00);
      end
    join

    // reset pulse while waiting for B: outputs drop at once, B is dropped
    b_dly = 5;
    exp_aw.push_back(15'h0050);
    exp_w.push_back({4'hF, 32'h7777_0050});
    fork
      do_write(0, 15'h0050, 32'h7777_0050, 4'hF, 0);
      begin
        repeat (3) @(negedge axi_clk);
        chk("wr_resp_bready", s_bready, 1);
        #3 axi_reset = 1'b1;
        #1 chk("async_reset_outputs", all_out, 0);
      end
    join
    b_dly = 0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset = 1'b0;
    @(posedge axi_clk);
    #1;

    rd_data = 32'h0F0F_1234;
    exp_read(1, 15'h0060, 32'h0F0F_1234);
    do_read(1, 15'h0060);

    exp_write(0, 15'h0070, 32'h1111_0070, 4'hF, 2'b00);
    exp_write(1, 15'h0074, 32'h2222_0074, 4'h6, 2'b00);
    fork
      do_write(0, 15'h0070, 32'h1111_0070, 4'hF, 0);
      do_write(1, 15'h0074, 32'h2222_0074, 4'h6, 0);
    join

    repeat (3) @(posedge axi_clk);
    #1;
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
    chk("b_left", exp_b.size(), 0);
    chk("ar_left", exp_ar.size(), 0);
    chk("r_left", exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_mst_arbiter.md
# axil_mst_arbiter

Two-master, one-slave AXI-Lite arbiter that shares the AXI-Lite configuration port of the axilite_axis bridge between two requesters (m0: local CPU path, m1: remote/io path). It allows one transaction at a time end to end, with round-robin fairness between masters and write-before-read priority within a master. It has no internal buffering: once a master holds the grant, its channels connect combinationally to the slave.

## Interface
- ADDR_WIDTH, 15, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width; strobe width is DATA_WIDTH/8.
- axi_clk  in  1  single clock for all logic.
- axi_reset  in  1  asynchronous, active-high reset.
- mN_awvalid/mN_awready, mN_awaddr  in/out, in  1/1, ADDR_WIDTH  master N write address (N = 0, 1).
- mN_wvalid/mN_wready, mN_wdata, mN_wstrb  in/out, in, in  1/1, DATA_WIDTH, DATA_WIDTH/8  master N write data.
- mN_bvalid/mN_bready, mN_bresp  out/in, out  1/1, 2  master N write response.
- mN_arvalid/mN_arready, mN_araddr  in/out, in  1/1, ADDR_WIDTH  master N read address.
- mN_rvalid/mN_rready, mN_rdata, mN_rresp  out/in, out, out  1/1, DATA_WIDTH, 2  master N read data.
- s_aw*, s_w*, s_b*, s_ar*, s_r*  mirrored directions  same widths  single slave port toward the bridge.

## Operation
- Master N requests when mN_awvalid or mN_arvalid is high. A lone wvalid is not a request.
- FSM states:
  - IDLE: nothing forwarded.
  - WR_REQ: forward AW and W.
  - WR_RESP: forward B.
  - RD_REQ: forward AR.
  - RD_RESP: forward R.
- IDLE grant selection:
  - One requester: it wins.
  - Both request: winner is the master not equal to last_gnt.
  - Within the winner: awvalid takes WR_REQ; otherwise RD_REQ.
  - grant and the direction are registered on entry.
- WR_REQ:
  - s_awvalid = m[g]_awvalid & ~aw_done.
  - s_wvalid = m[g]_wvalid & ~w_done.
  - Readies are routed back to m[g] only.
  - aw_done / w_done set on the respective slave handshake. AW and W may complete in either order or in the same cycle.
  - When both are done, or both complete this cycle, go to WR_RESP.
- WR_RESP:
  - s_bready = m[g]_bready; m[g]_bvalid = s_bvalid; bresp passes through.
  - On the s_bvalid & s_bready handshake: last_gnt <= g, clear done flags, go to IDLE.
- RD_REQ: forward AR; on the s_arvalid & s_arready handshake go to RD_RESP.
- RD_RESP: forward R; on the s_rvalid & s_rready handshake: last_gnt <= g, go to IDLE.
- Non-granted master:
  - All of its ready/valid outputs are held 0.
  - bresp, rresp and rdata outputs are driven 0.
  - Its pending request waits untouched.
- Slave outputs when no channel is forwarded: valids/readies 0; addr, data and strb 0.
- Masters must hold their request stable (AXI rule); the arbiter does not check this.

## Timing
- Reset state (asynchronous, immediate):
  - state = IDLE, last_gnt = 1 (so m0 wins first), aw_done = w_done = 0.
  - Every valid/ready output is 0; all data/resp outputs are 0.
- Arbitration latency: a request first seen in IDLE at cycle t appears on the slave at cycle t+1. Slave handshakes cost no extra cycle.
- At least one IDLE cycle between consecutive transactions, so peak throughput is one transaction per (arbitration + address + response) cycles.
- Simultaneous requests from both masters in IDLE: round-robin as above. The loser is granted on the next arbitration if it is still requesting.
- Slave B or R valid in the same cycle as the address handshake: accepted normally. The FSM must not miss it. Once the AW/W or AR handshake completes, the FSM advances to WR_RESP / RD_RESP in the same cycle so the response is forwarded.
- Reset asserted mid-transaction:
  - All outputs go to 0 asynchronously and the FSM returns to IDLE.
  - The in-flight transaction is dropped; the system reset covers the bridge too.
- Deassertion of reset: the first arbitration is evaluated on the first rising edge after release.

## Test plan
- m0 writes addr 0x0010, data 0xDEADBEEF, strb 0xF; slave readies are always 1 -> s_aw/s_w valid one cycle after request, m0_bvalid follows s_bvalid, resp 2'b00. m1 sees no activity.
- m0 and m1 both assert awvalid at the same cycle after reset:
  - m0 is granted first, then m1.
  - A second simultaneous pair is served m0 then m1 again (last_gnt alternates).
  - Slave write order is m0, m1, m0, m1.
- m1 asserts awvalid and arvalid together -> write served first, then the read. s_araddr equals m1_araddr and m1_rdata equals s_rdata (0x12345678).
- Slave delays: s_awready after 3 cycles, s_wready after 1 cycle, s_bvalid after 5 cycles:
  - No duplicate AW/W handshake occurs.
  - The master sees exactly one bvalid/bready handshake.
- m0 sends W before AW (wvalid 2 cycles earlier) -> no grant until awvalid; then a correct single write.
- axi_reset pulsed while in WR_RESP -> all outputs 0 in the same cycle. After release, a new m1 read completes normally and m0 wins a subsequent tie.
